// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester, multiplier and result signals of the shared multiplier
interface mult_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic               req0_valid;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_ready;
  logic               req1_valid;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_ready;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_p;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_p;
  logic               res_id;
  logic [CNT_W-1:0]   ops_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p, res_ready,
    output req0_ready, req1_ready, mul_a, mul_b, res_valid, res_p, res_id, ops_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p, res_ready,
    input  req0_ready, req1_ready, mul_a, mul_b, res_valid, res_p, res_id, ops_cnt
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one combinational multiplier between two requesters
module mult_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_OUT
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic               r_op_id;
  logic               r_last_id;
  logic [2*WIDTH-1:0] r_res_p;
  logic               r_res_id;
  logic [CNT_W-1:0]   r_ops_cnt;
  logic               w_grant;
  logic               w_slot_open;
  logic               w_ready0;
  logic               w_ready1;
  logic               w_accept;
  logic               w_res_fire;
  logic               w_res_valid;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_id;
    end else if (bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_slot_open = (r_state == ST_IDLE) || ((r_state == ST_OUT) && bus.res_ready);
  assign w_ready0    = rst_n && w_slot_open && bus.req0_valid && !w_grant;
  assign w_ready1    = rst_n && w_slot_open && bus.req1_valid && w_grant;
  assign w_accept    = w_ready0 || w_ready1;
  assign w_res_fire  = (r_state == ST_OUT) && bus.res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_res_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_MUL;
        end
      end
      ST_MUL: begin
        w_next_state = ST_OUT;
      end
      ST_OUT: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) begin
          w_next_state = w_accept ? ST_MUL : ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_id   <= 1'b0;
      r_last_id <= 1'b1;
      r_res_p   <= '0;
      r_res_id  <= 1'b0;
      r_ops_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op_a    <= w_grant ? bus.req1_a : bus.req0_a;
        r_op_b    <= w_grant ? bus.req1_b : bus.req0_b;
        r_op_id   <= w_grant;
        r_last_id <= w_grant;
      end
      if (r_state == ST_MUL) begin
        r_res_p  <= bus.mul_p;
        r_res_id <= r_op_id;
      end
      if (w_res_fire) begin
        r_ops_cnt <= r_ops_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.mul_a      = r_op_a;
  assign bus.mul_b      = r_op_b;
  assign bus.res_valid  = w_res_valid;
  assign bus.res_p      = r_res_p;
  assign bus.res_id     = r_res_id;
  assign bus.ops_cnt    = r_ops_cnt;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed bench for mult_share_arbiter, 16-bit and 4-bit counter instances
module tb_mult_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.WIDTH(8), .CNT_W(16)) bus ();
  mult_share_arbiter_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  mult_share_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mult_share_arbiter #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Stand-in for the combinational wallace_multiplier on each instance.
  assign bus.mul_p  = 16'(bus.mul_a) * 16'(bus.mul_b);
  assign bus4.mul_p = 16'(bus4.mul_a) * 16'(bus4.mul_b);

  assign bus4.req0_valid = bus.req0_valid;
  assign bus4.req0_a     = bus.req0_a;
  assign bus4.req0_b     = bus.req0_b;
  assign bus4.req1_valid = bus.req1_valid;
  assign bus4.req1_a     = bus.req1_a;
  assign bus4.req1_b     = bus.req1_b;
  assign bus4.res_ready  = bus.res_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      check_eq("ready0_needs_valid", 32'(bus.req0_ready & ~bus.req0_valid), 32'd0);
      check_eq("ready1_needs_valid", 32'(bus.req1_ready & ~bus.req1_valid), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 8'h00;
    bus.req0_b     = 8'h00;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 8'h00;
    bus.req1_b     = 8'h00;
    bus.res_ready  = 1'b0;

    repeat (2) @(posedge clk);
    mid();
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_res_p", 32'(bus.res_p), 32'd0);
    check_eq("rst_res_id", 32'(bus.res_id), 32'd0);
    check_eq("rst_ops_cnt", 32'(bus.ops_cnt), 32'd0);
    check_eq("rst_mul_a", 32'(bus.mul_a), 32'd0);
    check_eq("rst_mul_b", 32'(bus.mul_b), 32'd0);
    check_eq("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check_eq("rst_ready1", 32'(bus.req1_ready), 32'd0);
    check_eq("rst4_ops_cnt", 32'(bus4.ops_cnt), 32'd0);

    // single isolated op 0xFF*0xFF
    adv();
    rst_n = 1'b1;
    bus.req0_a = 8'hFF; bus.req0_b = 8'hFF;
    bus.req1_valid = 1'b0;
    bus.res_ready = 1'b1;
    mon_en = 1'b1;
    mid();
    check_eq("single_ready0", 32'(bus.req0_ready), 32'd1);
    check_eq("single_ready1", 32'(bus.req1_ready), 32'd0);
    adv();
    bus.req0_valid = 1'b0;
    mid();
    check_eq("single_mul_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("single_mul_a", 32'(bus.mul_a), 32'h00FF);
    check_eq("single_mul_b", 32'(bus.mul_b), 32'h00FF);
    adv(); mid();
    check_eq("single_res_valid", 32'(bus.res_valid), 32'd1);
    check_eq("single_res_p", 32'(bus.res_p), 32'hFE01);
    check_eq("single_res_id", 32'(bus.res_id), 32'd0);
    adv(); mid();
    check_eq("single_ops_cnt", 32'(bus.ops_cnt), 32'd1);
    check_eq("single_idle_valid", 32'(bus.res_valid), 32'd0);

    // tie from reset: req0 first, then alternation
    adv(); rst_n = 1'b0; mid();
    adv();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h0A; bus.req1_b = 8'h0B;
    mid();
    check_eq("tie_ready0", 32'(bus.req0_ready), 32'd1);
    check_eq("tie_ready1", 32'(bus.req1_ready), 32'd0);
    check_eq("tie_cnt_reset", 32'(bus.ops_cnt), 32'd0);
    adv(); mid();
    check_eq("tie_mul_ready1", 32'(bus.req1_ready), 32'd0);
    adv(); mid();
    check_eq("tie1_res_p", 32'(bus.res_p), 32'h03A8);
    check_eq("tie1_res_id", 32'(bus.res_id), 32'd0);
    check_eq("tie1_ready1", 32'(bus.req1_ready), 32'd1);
    adv(); mid();
    adv(); mid();
    check_eq("tie2_res_p", 32'(bus.res_p), 32'h006E);
    check_eq("tie2_res_id", 32'(bus.res_id), 32'd1);
    check_eq("tie2_ready0", 32'(bus.req0_ready), 32'd1);
    check_eq("tie2_ops_cnt", 32'(bus.ops_cnt), 32'd1);
    adv(); mid();
    adv();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    mid();
    check_eq("tie3_res_p", 32'(bus.res_p), 32'h03A8);
    check_eq("tie3_res_id", 32'(bus.res_id), 32'd0);
    check_eq("tie3_ops_cnt", 32'(bus.ops_cnt), 32'd2);
    adv(); mid();
    check_eq("tie_end_ops_cnt", 32'(bus.ops_cnt), 32'd3);
    check_eq("tie_end_valid", 32'(bus.res_valid), 32'd0);

    // backpressure: 5 cycles of res_ready low while both requesters wait
    adv();
    bus.req1_valid = 1'b1; bus.req1_a = 8'h05; bus.req1_b = 8'h07;
    bus.res_ready = 1'b0;
    mid();
    check_eq("bp_ready1", 32'(bus.req1_ready), 32'd1);
    adv();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h02; bus.req0_b = 8'h03;
    mid();
    for (int i = 0; i < 5; i++) begin
      adv(); mid();
      check_eq("bp_res_valid", 32'(bus.res_valid), 32'd1);
      check_eq("bp_res_p", 32'(bus.res_p), 32'h0023);
      check_eq("bp_res_id", 32'(bus.res_id), 32'd1);
      check_eq("bp_ready0", 32'(bus.req0_ready), 32'd0);
      check_eq("bp_ready1", 32'(bus.req1_ready), 32'd0);
    end
    check_eq("bp_cnt_hold", 32'(bus.ops_cnt), 32'd3);
    adv();
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    mid();
    check_eq("bp_release_p", 32'(bus.res_p), 32'h0023);
    adv(); mid();
    check_eq("bp_ops_cnt", 32'(bus.ops_cnt), 32'd4);
    check_eq("bp_idle_valid", 32'(bus.res_valid), 32'd0);

    // back-to-back on req1: 3*1 .. 3*10
    adv();
    bus.req1_valid = 1'b1; bus.req1_a = 8'd3; bus.req1_b = 8'd1;
    mid();
    check_eq("b2b_first_ready1", 32'(bus.req1_ready), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      adv();
      if (k < 10) bus.req1_b = 8'(k + 1);
      else bus.req1_valid = 1'b0;
      mid();
      check_eq("b2b_mul_valid", 32'(bus.res_valid), 32'd0);
      adv(); mid();
      check_eq("b2b_res_valid", 32'(bus.res_valid), 32'd1);
      check_eq("b2b_res_p", 32'(bus.res_p), 32'(3 * k));
      check_eq("b2b_res_id", 32'(bus.res_id), 32'd1);
      check_eq("b2b_ready1", 32'(bus.req1_ready), (k < 10) ? 32'd1 : 32'd0);
    end
    adv(); mid();
    check_eq("b2b_ops_cnt", 32'(bus.ops_cnt), 32'd14);
    check_eq("b2b_ops_cnt4", 32'(bus4.ops_cnt), 32'd14);

    // reset while in MUL discards the result
    adv();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h11;
    mid();
    check_eq("rmo_ready0", 32'(bus.req0_ready), 32'd1);
    adv();
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    mid();
    check_eq("rmo_mul_valid", 32'(bus.res_valid), 32'd0);
    adv();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h0A; bus.req1_b = 8'h0B;
    mid();
    check_eq("rmo_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rmo_ops_cnt", 32'(bus.ops_cnt), 32'd0);
    check_eq("rmo_res_p", 32'(bus.res_p), 32'd0);
    check_eq("rmo_tie_ready0", 32'(bus.req0_ready), 32'd1);
    check_eq("rmo_tie_ready1", 32'(bus.req1_ready), 32'd0);
    adv();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    mid();
    adv(); mid();
    check_eq("rmo_res_p_after", 32'(bus.res_p), 32'h03A8);
    check_eq("rmo_res_id_after", 32'(bus.res_id), 32'd0);
    adv(); mid();
    check_eq("rmo_ops_cnt_after", 32'(bus.ops_cnt), 32'd1);

    // 17 isolated ops: 4-bit counter wraps 15 -> 0 -> 1
    adv(); rst_n = 1'b0; mid();
    adv(); rst_n = 1'b1; mid();
    for (int i = 0; i < 17; i++) begin
      adv();
      bus.req0_valid = 1'b1; bus.req0_a = 8'(i + 1); bus.req0_b = 8'd2;
      mid();
      if (i == 15) check_eq("wrap_cnt4_15", 32'(bus4.ops_cnt), 32'd15);
      if (i == 16) check_eq("wrap_cnt4_0", 32'(bus4.ops_cnt), 32'd0);
      adv();
      bus.req0_valid = 1'b0;
      mid();
      adv(); mid();
      check_eq("wrap_res_p", 32'(bus.res_p), 32'(2 * (i + 1)));
    end
    adv(); mid();
    check_eq("wrap_cnt4_1", 32'(bus4.ops_cnt), 32'd1);
    check_eq("wrap_cnt16_17", 32'(bus.ops_cnt), 32'd17);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
